// File: rtl/amux_pkg.sv
// Shared constants for the analog multiplexer block.
package amux_pkg;
   localparam int unsigned AmuxSelWidth = 5;
endpackage

// File: rtl/amux_sequencer.sv
// aMUX scan controller: walks an enabled slot list, settles, runs the converter
// req/ack handshake and returns slot-tagged results.
module amux_sequencer #(
   parameter int unsigned NumSlots    = 8,
   parameter int unsigned SelWidth    = amux_pkg::AmuxSelWidth,
   parameter int unsigned SettleWidth = 16,
   parameter int unsigned DataWidth   = 12
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic                          start_i,
   input  logic                          continuous_i,
   input  logic                          stop_i,
   input  logic [NumSlots*SelWidth-1:0]  slot_sel_i,
   input  logic [NumSlots-1:0]           slot_en_i,
   input  logic [SettleWidth-1:0]        settle_cycles_i,
   output logic [SelWidth-1:0]           sel_o,
   output logic                          conv_req_o,
   input  logic                          conv_ack_i,
   input  logic [DataWidth-1:0]          conv_data_i,
   output logic                          sample_valid_o,
   output logic [$clog2(NumSlots)-1:0]   sample_slot_o,
   output logic [DataWidth-1:0]          sample_data_o,
   output logic                          sweep_done_o,
   output logic                          busy_o
);

   localparam int unsigned SlotWidth = $clog2(NumSlots);

   typedef enum logic [1:0] {IDLE, SETTLE, CONVERT} state_e;

   state_e                         state_q, state_d;
   logic [NumSlots*SelWidth-1:0]   snap_sel_q, snap_sel_d;
   logic [NumSlots-1:0]            snap_en_q, snap_en_d;
   logic [SettleWidth-1:0]         snap_settle_q, snap_settle_d;
   logic                           snap_cont_q, snap_cont_d;
   logic [SlotWidth-1:0]           cur_q, cur_d;
   logic [SettleWidth-1:0]         cnt_q, cnt_d;
   logic                           stop_q, stop_d;
   logic [SelWidth-1:0]            sel_d;
   logic                           sample_valid_d, sweep_done_d;
   logic [SlotWidth-1:0]           sample_slot_d;
   logic [DataWidth-1:0]           sample_data_d;

   logic                           first_found, next_found;
   logic [SlotWidth-1:0]           first_idx, next_idx;
   logic [SelWidth-1:0]            first_code, next_code;

   // Counter preload so that conv_req rises N cycles after the sel_o change;
   // after an ack at least one request-low cycle is always inserted.
   function automatic logic [SettleWidth-1:0] reload(input logic [SettleWidth-1:0] n);
      return (n == '0) ? '0 : n - SettleWidth'(1);
   endfunction

   // Downward scan so the lowest matching index wins.
   always_comb begin
      first_found = 1'b0;
      first_idx   = '0;
      first_code  = '0;
      next_found  = 1'b0;
      next_idx    = '0;
      next_code   = '0;
      for (int unsigned k = NumSlots; k > 0; k--) begin
         if (slot_en_i[k-1]) begin
            first_found = 1'b1;
            first_idx   = SlotWidth'(k - 1);
            first_code  = slot_sel_i[(k-1)*SelWidth +: SelWidth];
         end
         if (snap_en_q[k-1] && (SlotWidth'(k - 1) > cur_q)) begin
            next_found = 1'b1;
            next_idx   = SlotWidth'(k - 1);
            next_code  = snap_sel_q[(k-1)*SelWidth +: SelWidth];
         end
      end
   end

   always_comb begin
      state_d        = state_q;
      snap_sel_d     = snap_sel_q;
      snap_en_d      = snap_en_q;
      snap_settle_d  = snap_settle_q;
      snap_cont_d    = snap_cont_q;
      cur_d          = cur_q;
      cnt_d          = cnt_q;
      sel_d          = sel_o;
      sample_valid_d = 1'b0;
      sample_slot_d  = sample_slot_o;
      sample_data_d  = sample_data_o;
      sweep_done_d   = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (start_i) begin
               snap_sel_d    = slot_sel_i;
               snap_en_d     = slot_en_i;
               snap_settle_d = settle_cycles_i;
               snap_cont_d   = continuous_i;
               if (first_found) begin
                  cur_d   = first_idx;
                  sel_d   = first_code;
                  cnt_d   = reload(settle_cycles_i);
                  state_d = (settle_cycles_i == '0) ? CONVERT : SETTLE;
               end else begin
                  sweep_done_d = 1'b1;
               end
            end
         end
         SETTLE: begin
            if (cnt_q == '0) state_d = CONVERT;
            else             cnt_d   = cnt_q - SettleWidth'(1);
         end
         CONVERT: begin
            if (conv_ack_i) begin
               sample_valid_d = 1'b1;
               sample_slot_d  = cur_q;
               sample_data_d  = conv_data_i;
               if (next_found) begin
                  cur_d   = next_idx;
                  sel_d   = next_code;
                  cnt_d   = reload(snap_settle_q);
                  state_d = SETTLE;
               end else begin
                  sweep_done_d = 1'b1;
                  if (snap_cont_q && !(stop_q || stop_i) && first_found) begin
                     snap_sel_d    = slot_sel_i;
                     snap_en_d     = slot_en_i;
                     snap_settle_d = settle_cycles_i;
                     snap_cont_d   = continuous_i;
                     cur_d         = first_idx;
                     sel_d         = first_code;
                     cnt_d         = reload(settle_cycles_i);
                     state_d       = SETTLE;
                  end else begin
                     state_d = IDLE;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase

      stop_d = stop_q | (stop_i && (state_q != IDLE));
      if (state_d == IDLE) stop_d = 1'b0;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q        <= IDLE;
         snap_sel_q     <= '0;
         snap_en_q      <= '0;
         snap_settle_q  <= '0;
         snap_cont_q    <= 1'b0;
         cur_q          <= '0;
         cnt_q          <= '0;
         stop_q         <= 1'b0;
         sel_o          <= '0;
         conv_req_o     <= 1'b0;
         sample_valid_o <= 1'b0;
         sample_slot_o  <= '0;
         sample_data_o  <= '0;
         sweep_done_o   <= 1'b0;
         busy_o         <= 1'b0;
      end else begin
         state_q        <= state_d;
         snap_sel_q     <= snap_sel_d;
         snap_en_q      <= snap_en_d;
         snap_settle_q  <= snap_settle_d;
         snap_cont_q    <= snap_cont_d;
         cur_q          <= cur_d;
         cnt_q          <= cnt_d;
         stop_q         <= stop_d;
         sel_o          <= sel_d;
         conv_req_o     <= (state_d == CONVERT);
         sample_valid_o <= sample_valid_d;
         sample_slot_o  <= sample_slot_d;
         sample_data_o  <= sample_data_d;
         sweep_done_o   <= sweep_done_d;
         busy_o         <= (state_d != IDLE);
      end
   end

endmodule

// File: doc/amux_sequencer.md
# amux_sequencer

Scan controller for the analog multiplexer (`aMUX`). It steps the 5-bit `SEL` bus through a programmable list of up to `NumSlots` channels and waits a programmable settling time after each switch. It then runs a req/ack conversion handshake with the downstream ADC/front-end and returns each result tagged with its slot index. Sits between the register interface (configuration, start/stop) and the `aMUX` + converter pair; it is the only driver of `SEL`.

## Interface
- `NumSlots`, 8, number of scan-list entries (2..16)
- `SelWidth`, `amux_pkg::AmuxSelWidth` (5), width of a channel select
- `SettleWidth`, 16, width of settle-cycle counter
- `DataWidth`, 12, conversion result width

- `clk_i`  in  1  clock; single clock domain
- `rst_ni`  in  1  reset, asynchronous assert, active-low
- `start_i`  in  1  one-cycle pulse: begin a sweep (ignored while `busy_o`=1)
- `continuous_i`  in  1  level: sampled at start; 1 = restart sweeps back-to-back
- `stop_i`  in  1  pulse: finish current sweep, then go idle
- `slot_sel_i`  in  NumSlots*SelWidth  channel code per slot (slot k at bits k*SelWidth +: SelWidth)
- `slot_en_i`  in  NumSlots  per-slot enable
- `settle_cycles_i`  in  SettleWidth  wait cycles between `sel_o` change and `conv_req_o`
- `sel_o`  out  SelWidth  drives `aMUX.SEL`
- `conv_req_o`  out  1  conversion request
- `conv_ack_i`  in  1  conversion done; `conv_data_i` valid in same cycle
- `conv_data_i`  in  DataWidth  conversion result
- `sample_valid_o`  out  1  one-cycle pulse: result available
- `sample_slot_o`  out  $clog2(NumSlots)  slot index of result
- `sample_data_o`  out  DataWidth  captured result
- `sweep_done_o`  out  1  one-cycle pulse at end of each sweep
- `busy_o`  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, SETTLE, CONVERT.
- IDLE: `sel_o` holds its last value. On `start_i`:
  - snapshot `slot_sel_i`, `slot_en_i`, `settle_cycles_i`, `continuous_i` into internal registers; the sweep uses only these snapshots.
  - if no slot is enabled: pulse `sweep_done_o` next cycle and stay IDLE.
  - otherwise load the lowest enabled index, drive its code on `sel_o`, load the counter with settle, and go to SETTLE.
- SETTLE: counter decrements each cycle; when it is 0, go to CONVERT. `conv_req_o`=0.
- CONVERT: `conv_req_o`=1 and held until `conv_ack_i` is sampled high. On ack:
  - capture data into `sample_data_o`; pulse `sample_valid_o` with the current slot.
  - next slot = next enabled index above the current one.
  - if one exists: update `sel_o`, reload the counter, go to SETTLE.
  - if none (sweep end): pulse `sweep_done_o`.
    - If the continuous flag is 1 and no stop is pending: wrap to the lowest enabled index and go to SETTLE with a new snapshot of the config inputs.
    - Else go to IDLE.
- `stop_i` in any non-IDLE state sets a stop-pending flag, cleared on entering IDLE. The current sweep always completes. `stop_i` in IDLE has no effect.
- `conv_ack_i` outside CONVERT is ignored.
- Only one enabled slot: it is converted repeatedly; in continuous mode each pass pulses `sweep_done_o`.

## Timing
- Reset values:
  - `sel_o`=0, `conv_req_o`=0, `sample_valid_o`=0, `sample_slot_o`=0, `sample_data_o`=0, `sweep_done_o`=0, `busy_o`=0.
  - FSM in IDLE; all snapshot registers 0.
- All outputs are registered.
- `start_i` sampled at edge t0: `sel_o` and `busy_o` valid at t0+1.
- `conv_req_o` rises at t0+1+N, where N is the snapshotted settle count (N=0 → same cycle as the `sel_o` change).
- Ack sampled at edge ta, in the cycle after ta:
  - `conv_req_o`=0;
  - `sample_valid_o`=1 and `sample_slot_o`/`sample_data_o` valid;
  - `sel_o` changes to the next slot, or holds at sweep end;
  - `sweep_done_o`=1 if this was the last slot.
- Next request at ta+1+N. Ack in the same cycle req rises is legal: minimum of 1 cycle in CONVERT.
- Idle at sweep end: `busy_o` falls in the cycle after ta, concurrent with `sweep_done_o`.
- Asynchronous reset mid-handshake: `conv_req_o` drops immediately; no sample or done pulse is emitted.

## Test plan
- Single sweep:
  - stimulus: slots 0,2,5 enabled with codes 3,1,4; settle 10; ack 3 cycles after each req.
  - expect `sel_o` sequence 3→1→4; three `sample_valid_o` pulses with slots 0,2,5; `sweep_done_o` on the third; `busy_o` falls.
  - expect req-to-`sel_o` spacing of exactly 10 cycles.
- Settle 0, instant ack:
  - stimulus: all 8 slots enabled.
  - expect a new sample every 2 cycles; 8 samples, then done.
- Empty list: `slot_en_i`=0 with start → one `sweep_done_o` pulse; `busy_o` never high; `sel_o` unchanged.
- Continuous + stop:
  - stimulus: 2 slots, `continuous_i`=1; `stop_i` pulsed mid-way through the 3rd sweep.
  - expect exactly 3 `sweep_done_o` pulses, then IDLE.
- Snapshot and glitch rejection:
  - stimulus: change `slot_sel_i` and `settle_cycles_i` mid-sweep; pulse `start_i` while busy; pulse `conv_ack_i` during SETTLE.
  - expect the sweep to use the original values, no restart, and no extra sample.
- Reset mid-CONVERT: `conv_req_o` goes 0 asynchronously; all outputs return to reset values; a new start afterwards behaves as in the single-sweep test.
